// File: rtl/mult_unit.sv
// Iterative signed 32x32 shift-add multiplier for the MULT/MFLO path.
// Multiplies operand magnitudes in 32 steps, then applies the sign on a final cycle.
module mult_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] mcand;
    logic [63:0] acc;
    logic        neg;
    logic [5:0]  cnt;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] psum;
    logic [63:0] result;

    // Magnitudes are 32-bit unsigned, so |0x80000000| stays 0x80000000.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        a_mag  = A;
        b_mag  = B;
        psum   = {1'b0, acc[63:32]};
        result = acc;
        if (A[31]) a_mag = ~A + 32'd1;
        if (B[31]) b_mag = ~B + 32'd1;
        if (acc[0]) psum = {1'b0, acc[63:32]} + {1'b0, mcand};
        if (neg) result = ~acc + 64'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 6'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand <= 32'd0;
            acc   <= 64'd0;
            neg   <= 1'b0;
            cnt   <= 6'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        acc   <= {32'd0, b_mag};
                        neg   <= A[31] ^ B[31];
                        cnt   <= 6'd0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // Carry out of the upper-half add shifts into bit 63.
                    acc <= {psum, acc[31:1]};
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    {HI, LO} <= result;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
